local_port_buffer: RTL and testbench
====================================

LOCAL_PORT_BUFFER -- requirements
Module: local_port_buffer

Interface
REQ-001 Parameter PACKET_WIDTH, default 56, SHALL set the packet bus width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the FIFO entry count; legal values are powers of two, 2..16.
REQ-003 Parameter ROUTER_ID, default 6'b010_010, SHALL hold the owning router's ID, two 3-bit mesh coordinates.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 ReqUpStr  input  1  SHALL be the injector's request; held high until a grant is seen.
REQ-007 PacketIn  input  PACKET_WIDTH  SHALL be the injector packet; valid while ReqUpStr is high.
REQ-008 GntUpStr  output  1  SHALL be a one-cycle grant pulse to the injector.
REQ-009 Full  output  1  SHALL be the buffer-full indicator to the injector, wired to its DnStrFull.
REQ-010 ReqDnStr  output  1  SHALL be the request to the router switch allocator.
REQ-011 GntDnStr  input  1  SHALL be the one-cycle grant from the allocator.
REQ-012 DnStrFull  input  1  SHALL be the full indicator from the allocated output port.
REQ-013 PacketOut  output  PACKET_WIDTH  SHALL present the head entry.
REQ-014 Empty  output  1  SHALL be high when no entry is stored.
REQ-015 Occupancy  output  clog2(DEPTH)+1  SHALL give the stored entry count.

Function
REQ-016 Accept SHALL occur when ReqUpStr=1, Full=0 and GntUpStr=0 in the same cycle; PacketIn is written at that edge.
REQ-017 GntUpStr SHALL be 1 in exactly the cycle after each accept.
REQ-018 No accept SHALL occur while GntUpStr=1, because the injector's request is still high in that cycle.
REQ-019 Full SHALL equal (Occupancy==DEPTH); Empty SHALL equal (Occupancy==0). Both are combinational from registered state.
REQ-020 The output FSM SHALL have three states: D_IDLE, D_REQ and D_HOLD.
REQ-021 D_IDLE SHALL move to D_REQ when Empty=0 and DnStrFull=0; ReqDnStr=1 in D_REQ only.
REQ-022 In D_REQ, GntDnStr=1 SHALL pop the head and move to D_HOLD.
REQ-023 In D_REQ, DnStrFull rising without a grant SHALL return the FSM to D_IDLE with no pop.
REQ-024 D_HOLD SHALL last one cycle, with ReqDnStr=0, then return to D_IDLE.
REQ-025 GntDnStr outside D_REQ SHALL be ignored.
REQ-026 PacketOut SHALL be stable from entry into D_REQ until the pop.
REQ-027 PacketOut SHALL read all-zero when the buffer is empty.
REQ-028 Simultaneous accept and pop SHALL leave Occupancy unchanged.
REQ-029 Accept while full SHALL be impossible, and pop while empty SHALL be impossible.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Packet contents SHALL pass through unmodified, with no field decoding.

Reset
REQ-032 With reset=1 at an edge, the block SHALL clear pointers and Occupancy, and set the FSM to D_IDLE.
REQ-033 With reset=1 at an edge, GntUpStr and ReqDnStr SHALL be 0; Empty SHALL be 1 and Full SHALL be 0.
REQ-034 Reset mid-handshake SHALL drop any pending grant or request; stored packets are discarded and memory contents are not cleared.

Configuration
REQ-035 With LPB_STATS_EN defined, the block SHALL add two 16-bit outputs, AcceptCount and ForwardCount.
REQ-036 AcceptCount and ForwardCount SHALL increment on accept and pop respectively, wrap 0xFFFF to 0, and clear on reset.
REQ-037 Without LPB_STATS_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-038 Shared package noc_pkg SHALL hold PACKET_WIDTH, the packet field offsets (PacketID[9:0], SourceID[5:0], RandomInfo[9:0]) and the output-FSM state encoding.
REQ-039 Storage SHALL be a sub-module, lpb_fifo_mem: a dual-pointer register array with one write port and one read port.

Verification
REQ-040 Single packet: reset, then ReqUpStr=1 with PacketIn=0x2A; the bench SHALL see GntUpStr pulse at cycle +1 and ReqDnStr=1 at cycle +2 with PacketOut=0x2A; GntDnStr then gives Empty=1.
REQ-041 Fill: with GntDnStr=0 and 4 back-to-back requests, the bench SHALL see Full=1 and Occupancy=4, and a 5th request SHALL receive no grant.
REQ-042 Concurrent: Occupancy=2, then accept and pop in the same cycle; the bench SHALL see Occupancy remain 2 and FIFO order preserved.
REQ-043 Backpressure: DnStrFull=1 while in D_REQ; the bench SHALL see ReqDnStr fall next cycle with no pop, and the request reassert after DnStrFull=0.
REQ-044 Wrap: 10 packets 1..10 streamed through DEPTH=4; the bench SHALL see output order 1..10.
REQ-045 Reset during WAIT: reset asserted while GntUpStr=1; the bench SHALL see GntUpStr=0, Occupancy=0 and Empty=1 on the next cycle.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC packet width, packet field offsets and the
// local-port output FSM state encoding.
package noc_pkg;
    localparam int PACKET_WIDTH = 56;
    localparam int PACKET_ID_LSB = 0;
    localparam int PACKET_ID_W = 10;
    localparam int SOURCE_ID_LSB = 10;
    localparam int SOURCE_ID_W = 6;
    localparam int RANDOM_INFO_LSB = 16;
    localparam int RANDOM_INFO_W = 10;
    typedef enum logic [1:0] {D_IDLE = 2'd0, D_REQ = 2'd1, D_HOLD = 2'd2} dnState_t;
endpackage

// File: rtl/lpb_fifo_mem.sv
// lpb_fifo_mem: register-array storage with one write port and one
// asynchronous read port; contents are never cleared.
module lpb_fifo_mem #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wrEn) mem[wrAddr] <= wrData;

    assign rdData = mem[rdAddr];
endmodule

// File: rtl/local_port_buffer.sv
// local_port_buffer: injector-side FIFO feeding a router switch allocator.
// Define LPB_STATS_EN to add the AcceptCount/ForwardCount statistics outputs.
module local_port_buffer #(
    parameter int           PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
    parameter int           DEPTH = 4,
    parameter logic [5:0]   ROUTER_ID = 6'b010_010
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ReqUpStr,
    input  logic [PACKET_WIDTH-1:0]  PacketIn,
    output logic                     GntUpStr,
    output logic                     Full,
    output logic                     ReqDnStr,
    input  logic                     GntDnStr,
    input  logic                     DnStrFull,
    output logic [PACKET_WIDTH-1:0]  PacketOut,
    output logic                     Empty,
`ifdef LPB_STATS_EN
    output logic [15:0]              AcceptCount,
    output logic [15:0]              ForwardCount,
`endif
    output logic [$clog2(DEPTH):0]   Occupancy
);
    import noc_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic [PACKET_WIDTH-1:0] headData;
    logic accept, pop;
    dnState_t state;

    assign Full = count == (AW+1)'(DEPTH);
    assign Empty = count == '0;
    assign Occupancy = count;
    // The grant cycle blocks acceptance: the injector's request is still high then.
    assign accept = ReqUpStr && !Full && !GntUpStr;
    assign pop = (state == D_REQ) && GntDnStr;
    assign ReqDnStr = state == D_REQ;
    assign PacketOut = Empty ? '0 : headData;

    lpb_fifo_mem #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) mem (
        .clk(clk),
        .wrEn(accept),
        .wrAddr(wrPtr),
        .wrData(PacketIn),
        .rdAddr(rdPtr),
        .rdData(headData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            GntUpStr <= 1'b0;
            state <= D_IDLE;
        end else begin
            GntUpStr <= accept;
            if (accept) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            unique case (state)
                D_IDLE: state <= (!Empty && !DnStrFull) ? D_REQ : D_IDLE;
                D_REQ:  state <= GntDnStr ? D_HOLD : (DnStrFull ? D_IDLE : D_REQ);
                default: state <= D_IDLE;
            endcase
        end
    end

`ifdef LPB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            AcceptCount <= '0;
            ForwardCount <= '0;
        end else begin
            if (accept) AcceptCount <= AcceptCount + 16'd1;
            if (pop) ForwardCount <= ForwardCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_local_port_buffer.sv
// tb_local_port_buffer: directed self-checking bench for local_port_buffer.
module tb_local_port_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ReqUpStr = 1'b0;
    logic [55:0] PacketIn = '0;
    logic GntUpStr, Full, ReqDnStr, Empty;
    logic GntDnStr = 1'b0;
    logic DnStrFull = 1'b0;
    logic [55:0] PacketOut;
    logic [2:0] Occupancy;
`ifdef LPB_STATS_EN
    logic [15:0] AcceptCount, ForwardCount;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    local_port_buffer dut (
        .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
        .GntUpStr(GntUpStr), .Full(Full), .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr),
        .DnStrFull(DnStrFull), .PacketOut(PacketOut), .Empty(Empty),
`ifdef LPB_STATS_EN
        .AcceptCount(AcceptCount), .ForwardCount(ForwardCount),
`endif
        .Occupancy(Occupancy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [55:0] d);
        ReqUpStr = 1'b1;
        PacketIn = d;
        step();
        tests++;
        if (GntUpStr !== 1'b1) begin
            fails++;
            $display("FAIL push_grant data=%h got GntUpStr=%b want 1", d, GntUpStr);
        end
        ReqUpStr = 1'b0;
        step();
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (ReqDnStr !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        tests++;
        if (ReqDnStr !== 1'b1) begin
            fails++;
            $display("FAIL %s_req_timeout got ReqDnStr=%b want 1", name, ReqDnStr);
        end
    endtask

    task automatic popOne(input logic [55:0] exp, input string name);
        waitReq(name);
        tests++;
        if (PacketOut !== exp) begin
            fails++;
            $display("FAIL %s_order got PacketOut=%h want %h", name, PacketOut, exp);
        end
        GntDnStr = 1'b1;
        step();
        GntDnStr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if ({GntUpStr, ReqDnStr, Empty, Full} !== 4'b0010 || Occupancy !== 3'd0 || PacketOut !== '0) begin
            fails++;
            $display("FAIL reset_state got gnt=%b req=%b empty=%b full=%b occ=%0d out=%h want 0 0 1 0 0 0",
                     GntUpStr, ReqDnStr, Empty, Full, Occupancy, PacketOut);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        ReqUpStr = 1'b1;
        PacketIn = 56'h2A;
        step();
        tests++;
        if (GntUpStr !== 1'b1 || ReqDnStr !== 1'b0 || Occupancy !== 3'd1) begin
            fails++;
            $display("FAIL single_cyc1 got gnt=%b req=%b occ=%0d want 1 0 1", GntUpStr, ReqDnStr, Occupancy);
        end
        ReqUpStr = 1'b0;
        step();
        tests++;
        if (GntUpStr !== 1'b0 || ReqDnStr !== 1'b1 || PacketOut !== 56'h2A) begin
            fails++;
            $display("FAIL single_cyc2 got gnt=%b req=%b out=%h want 0 1 2a", GntUpStr, ReqDnStr, PacketOut);
        end
        GntDnStr = 1'b1;
        step();
        GntDnStr = 1'b0;
        tests++;
        if (Empty !== 1'b1 || ReqDnStr !== 1'b0 || PacketOut !== '0) begin
            fails++;
            $display("FAIL single_pop got empty=%b req=%b out=%h want 1 0 0", Empty, ReqDnStr, PacketOut);
        end
        step();
        tests++;
        if (ReqDnStr !== 1'b0) begin
            fails++;
            $display("FAIL single_idle got ReqDnStr=%b want 0", ReqDnStr);
        end
`ifdef LPB_STATS_EN
        tests++;
        if (AcceptCount !== 16'd1 || ForwardCount !== 16'd1) begin
            fails++;
            $display("FAIL stats got acc=%0d fwd=%0d want 1 1", AcceptCount, ForwardCount);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push(56'h10 + 56'(i));
        tests++;
        if (Full !== 1'b1 || Occupancy !== 3'd4 || Empty !== 1'b0) begin
            fails++;
            $display("FAIL fill_full got full=%b occ=%0d empty=%b want 1 4 0", Full, Occupancy, Empty);
        end
        ReqUpStr = 1'b1;
        PacketIn = 56'hFF;
        step();
        step();
        tests++;
        if (GntUpStr !== 1'b0 || Occupancy !== 3'd4) begin
            fails++;
            $display("FAIL fill_fifth got gnt=%b occ=%0d want 0 4", GntUpStr, Occupancy);
        end
        ReqUpStr = 1'b0;
        for (int i = 0; i < 4; i++) popOne(56'h10 + 56'(i), "fill");
        step();
        tests++;
        if (Empty !== 1'b1) begin
            fails++;
            $display("FAIL fill_drain got Empty=%b want 1", Empty);
        end
    endtask

    task automatic test_concurrent();
        push(56'hA1);
        push(56'hA2);
        waitReq("conc");
        ReqUpStr = 1'b1;
        PacketIn = 56'hA3;
        GntDnStr = 1'b1;
        step();
        ReqUpStr = 1'b0;
        GntDnStr = 1'b0;
        tests++;
        if (Occupancy !== 3'd2 || GntUpStr !== 1'b1) begin
            fails++;
            $display("FAIL conc_occ got occ=%0d gnt=%b want 2 1", Occupancy, GntUpStr);
        end
        popOne(56'hA2, "conc");
        popOne(56'hA3, "conc");
    endtask

    task automatic test_backpressure();
        push(56'h55);
        waitReq("bp");
        DnStrFull = 1'b1;
        step();
        tests++;
        if (ReqDnStr !== 1'b0 || Occupancy !== 3'd1) begin
            fails++;
            $display("FAIL bp_drop got req=%b occ=%0d want 0 1", ReqDnStr, Occupancy);
        end
        GntDnStr = 1'b1;
        step();
        GntDnStr = 1'b0;
        tests++;
        if (ReqDnStr !== 1'b0 || Occupancy !== 3'd1) begin
            fails++;
            $display("FAIL bp_stray_grant got req=%b occ=%0d want 0 1", ReqDnStr, Occupancy);
        end
        DnStrFull = 1'b0;
        step();
        tests++;
        if (ReqDnStr !== 1'b1 || PacketOut !== 56'h55) begin
            fails++;
            $display("FAIL bp_reassert got req=%b out=%h want 1 55", ReqDnStr, PacketOut);
        end
        popOne(56'h55, "bp");
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 3; i++) push(56'(i));
        for (int i = 4; i <= 10; i++) begin
            popOne(56'(i - 3), "wrap");
            push(56'(i));
        end
        for (int i = 8; i <= 10; i++) popOne(56'(i), "wrap");
        step();
        tests++;
        if (Empty !== 1'b1 || Occupancy !== 3'd0) begin
            fails++;
            $display("FAIL wrap_empty got empty=%b occ=%0d want 1 0", Empty, Occupancy);
        end
    endtask

    task automatic test_reset_wait();
        ReqUpStr = 1'b1;
        PacketIn = 56'h77;
        step();
        tests++;
        if (GntUpStr !== 1'b1) begin
            fails++;
            $display("FAIL rstw_pending got GntUpStr=%b want 1", GntUpStr);
        end
        reset = 1'b1;
        ReqUpStr = 1'b0;
        step();
        tests++;
        if (GntUpStr !== 1'b0 || Occupancy !== 3'd0 || Empty !== 1'b1 || ReqDnStr !== 1'b0) begin
            fails++;
            $display("FAIL rstw_state got gnt=%b occ=%0d empty=%b req=%b want 0 0 1 0",
                     GntUpStr, Occupancy, Empty, ReqDnStr);
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_concurrent();
        test_backpressure();
        test_wrap();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
